// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer for the execute stage.
//
// Runs beside the single-cycle ALU. An accepted op latches operand magnitudes
// and the result sign, iterates 32 cycles of shift-add (multiply) or restoring
// shift-subtract (divide) in a shared 64-bit accumulator, fixes up the sign in
// one cycle, then pulses done_o for one cycle with the result on result_o.
// Divide-by-zero and signed overflow bypass the iteration entirely.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start_i   EX holds an M-extension op with valid operands
//   funct3_i  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//             100 DIV, 101 DIVU, 110 REM, 111 REMU
//   rs1_i     operand A (multiplicand / dividend)
//   rs2_i     operand B (multiplier / divisor)
//   flush_i   kill the in-flight op
//   stall_o   freeze IF/ID/EX registers
//   done_o    one-cycle pulse, result_o valid
//   result_o  selected result, held until the next result load
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    FIX,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [5:0]          cnt_q;
  logic [2:0]          f3_q;
  logic                sign_q;
  logic [XLEN-1:0]     opnd_q;   // multiplicand (MUL) or divisor (DIV) magnitude
  logic [2*XLEN-1:0]   acc_q;    // MUL: product/multiplier; DIV: {remainder, quotient}

  // Conditional two's-complement negation, word and double-word flavours.
  function automatic logic [XLEN-1:0] neg_if(input logic neg, input logic [XLEN-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_if2(input logic neg, input logic [2*XLEN-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

  // Operand decode for the accept edge.
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, fast, accept_st;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (funct3_i)
      3'b000, 3'b001, 3'b100, 3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end
      3'b010:                         a_signed = 1'b1;
      default:                        ;
    endcase
  end

  assign a_neg    = a_signed & rs1_i[XLEN-1];
  assign b_neg    = b_signed & rs2_i[XLEN-1];
  assign a_mag    = neg_if(a_neg, rs1_i);
  assign b_mag    = neg_if(b_neg, rs2_i);
  assign div_zero = funct3_i[2] && (rs2_i == '0);
  assign div_ovf  = funct3_i[2] && !funct3_i[0] &&
                    (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);
  assign fast     = div_zero || div_ovf;
  assign accept_st = (state_q == IDLE) || (state_q == DONE);

  // Iteration datapath.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_sh;
  logic              div_ok;
  logic [XLEN-1:0]   div_rem;
  logic [2*XLEN-1:0] div_next;

  // Shift-add: add multiplicand into the high half when the multiplier LSB
  // is set, then shift the whole accumulator right with the carry.
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // Restoring divide: shift the next dividend bit into the partial remainder
  // and subtract the divisor only when it fits. div_sh < 2*divisor, so the
  // XLEN-bit difference is exact whenever the subtraction is taken.
  assign div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_ok   = div_sh >= {1'b0, opnd_q};
  assign div_rem  = div_sh[XLEN-1:0] - opnd_q;
  assign div_next = div_ok ? {div_rem,          acc_q[XLEN-2:0], 1'b1}
                           : {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

  // Sign fix-up and result selection.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, fix_val;

  assign prod_fix = neg_if2(sign_q, acc_q);
  assign quot_fix = neg_if(sign_q, acc_q[XLEN-1:0]);
  assign rem_fix  = neg_if(sign_q, acc_q[2*XLEN-1:XLEN]);

  always_comb begin
    fix_val = '0;
    case (f3_q)
      3'b000:                 fix_val = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_val = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_val = quot_fix;
      default:                fix_val = rem_fix;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state; flush wins over everything, including a simultaneous start.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_i) state_d = fast ? DONE : (funct3_i[2] ? DIV : MUL);
          else         state_d = IDLE;
        end
        MUL, DIV: if (cnt_q == 6'd31) state_d = FIX;
        FIX:      state_d = DONE;
        default:  state_d = IDLE;
      endcase
    end
  end

  assign stall_o = !flush_i &&
                   ((state_q == MUL) || (state_q == DIV) || (state_q == FIX) ||
                    (start_i && accept_st));
  assign done_o  = (state_q == DONE);

  // Operand latch, iteration and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      f3_q     <= '0;
      sign_q   <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      result_o <= '0;
    end else if (flush_i) begin
      cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            f3_q   <= funct3_i;
            cnt_q  <= '0;
            // Remainder takes the dividend's sign; products/quotients take A^B.
            sign_q <= (funct3_i[2] && funct3_i[1]) ? a_neg : (a_neg ^ b_neg);
            if (div_zero) begin
              result_o <= funct3_i[1] ? rs1_i : '1;
            end else if (div_ovf) begin
              result_o <= funct3_i[1] ? '0 : rs1_i;
            end else if (funct3_i[2]) begin
              opnd_q <= b_mag;
              acc_q  <= {{XLEN{1'b0}}, a_mag};
            end else begin
              opnd_q <= a_mag;
              acc_q  <= {{XLEN{1'b0}}, b_mag};
            end
          end
        end
        MUL: begin
          acc_q <= mul_next;
          cnt_q <= (cnt_q == 6'd31) ? 6'd0 : cnt_q + 6'd1;
        end
        DIV: begin
          acc_q <= div_next;
          cnt_q <= (cnt_q == 6'd31) ? 6'd0 : cnt_q + 6'd1;
        end
        FIX: result_o <= fix_val;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
`timescale 1ns/1ps
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [2:0]  funct3_i = 3'b000;
  logic [31:0] rs1_i = '0;
  logic [31:0] rs2_i = '0;
  logic        stall_o, done_o;
  logic [31:0] result_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
    int          c0;
    int          lat;
  } sb_t;
  sb_t sb[$];

  muldiv_seq #(.XLEN(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .funct3_i (funct3_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .flush_i  (flush_i),
    .stall_o  (stall_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference RV32M model built on native 64-bit arithmetic.
  function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sa, sbv, ua, ub, p;
    logic signed [31:0] q;
    logic               ovf;
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    q   = '0;
    case (f)
      3'd0: begin p = sa * sbv; return p[31:0];  end
      3'd1: begin p = sa * sbv; return p[63:32]; end
      3'd2: begin p = sa * ub;  return p[63:32]; end
      3'd3: begin p = ua * ub;  return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf)    return 32'h8000_0000;
        q = $signed(a) / $signed(b);
        return q;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf)    return 32'h0;
        q = $signed(a) % $signed(b);
        return q;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 34;
  endfunction

  task automatic sb_push(input string tag, input logic [31:0] exp, input int lat);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    e.c0  = cyc;
    e.lat = lat;
    sb.push_back(e);
  endtask

  // Done monitor: every done_o pulse must match the oldest outstanding op.
  always @(posedge clk) begin
    sb_t e;
    #1;
    if (done_o === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_done", done_o, 1'b0);
      end else begin
        e = sb.pop_front();
        chk({e.tag, "_res"}, result_o, e.exp);
        chk({e.tag, "_lat"}, cyc - e.c0, e.lat);
      end
    end
  end

  task automatic wait_sb(input string tag);
    int guard = 0;
    while (sb.size() != 0 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_timeout"}, sb.size(), 0);
    sb.delete();
  endtask

  // One op: drive start for one cycle, count stall cycles until done.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int lat;
    int n_stall = 0;
    int guard = 0;
    lat = exp_lat(f, a, b);
    @(negedge clk);
    flush_i = 1'b0;
    start_i = 1'b1;
    funct3_i = f;
    rs1_i = a;
    rs2_i = b;
    sb_push(tag, exp, lat);
    #1;
    if (stall_o) n_stall++;
    @(negedge clk);
    start_i = 1'b0;
    #1;
    while (sb.size() != 0 && guard < 60) begin
      if (stall_o) n_stall++;
      @(negedge clk);
      #1;
      guard++;
    end
    chk({tag, "_timeout"}, sb.size(), 0);
    sb.delete();
    chk({tag, "_stall"}, n_stall, lat);
  endtask

  initial begin
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    int          n_done;

    // Reset state.
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_done", done_o, 1'b0);
    chk("rst_stall", stall_o, 1'b0);
    chk("rst_result", result_o, 32'h0);
    rst_n = 1'b1;

    // Multiply family.
    run_op("mul",    3'b000, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE);
    run_op("mulh",   3'b001, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF);
    run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Divide family.
    run_op("div",  3'b100, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD);
    run_op("rem",  3'b110, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF);
    run_op("divu", 3'b101, 32'hFFFF_FFF9, 32'h2, 32'h7FFF_FFFC);
    run_op("remu", 3'b111, 32'd100, 32'd7, 32'd2);

    // Fast paths.
    run_op("div0",   3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_op("rem0",   3'b110, 32'd5, 32'd0, 32'd5);
    run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    run_op("divuff", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);

    // Random ops against the reference model.
    for (int i = 0; i < 12; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i % 4 == 0) ? 32'h0 : $urandom;
      run_op("rnd", rf, ra, rb, ref_md(rf, ra, rb));
    end

    // Flush at iteration 10 of a DIV, with a start in the flush cycle.
    @(negedge clk);
    start_i = 1'b1; funct3_i = 3'b100; rs1_i = 32'd1000; rs2_i = 32'd7;
    @(negedge clk);
    start_i = 1'b0;
    repeat (10) @(negedge clk);
    flush_i = 1'b1; start_i = 1'b1; funct3_i = 3'b000; rs1_i = 32'd5; rs2_i = 32'd5;
    #1;
    chk("flush_stall", stall_o, 1'b0);
    run_op("post_flush", 3'b111, 32'd100, 32'd7, 32'd2);

    // Back-to-back: start held high through DONE.
    @(negedge clk);
    start_i = 1'b1; funct3_i = 3'b000; rs1_i = 32'd7; rs2_i = 32'd6;
    sb_push("b2b_first", 32'd42, 34);
    @(negedge clk);
    rs1_i = 32'd3; rs2_i = 32'd4;
    begin
      int guard = 0;
      while (sb.size() != 0 && guard < 60) begin
        @(negedge clk);
        guard++;
      end
    end
    #1;
    chk("b2b_first_timeout", sb.size(), 0);
    sb.delete();
    chk("b2b_done_stall", stall_o, 1'b1);
    sb_push("b2b_second", 32'd12, 34);
    @(negedge clk);
    start_i = 1'b0;
    wait_sb("b2b_second");

    // Reset mid-MUL: outputs clear at once and no done follows.
    @(negedge clk);
    start_i = 1'b1; funct3_i = 3'b000; rs1_i = 32'd5; rs2_i = 32'd9;
    @(negedge clk);
    start_i = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_done", done_o, 1'b0);
    chk("midrst_stall", stall_o, 1'b0);
    chk("midrst_result", result_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_o) n_done++;
    end
    chk("midrst_no_done", n_done, 0);
    chk("midrst_result_hold", result_o, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
